// File: rtl/alu_instr_encoder_if.sv
// Request/issue bus of the ALU instruction encoder. The master side
// drives encode requests and accepts issued R-type words.
interface alu_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ctrl;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  func;
    logic [6:0]  opcode;

    modport master (
        output req_valid, req_ctrl, req_rs1, req_rs2, req_rd, instr_ready,
        input  req_ready, instr_valid, instr, func, opcode
    );

    modport slave (
        input  req_valid, req_ctrl, req_rs1, req_rs2, req_rd, instr_ready,
        output req_ready, instr_valid, instr, func, opcode
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// Encodes ALU control codes into RV32 R-type words, buffers them in a small
// issue queue and releases them no closer than ISSUE_GAP cycles apart.
module alu_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_instr_encoder_if.slave     bus,
    output logic                   err_illegal,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [6:0] OPC_OP = 7'b0110011;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

    // Returns {legal, funct7[5], funct3} for a control code.
    function automatic logic [4:0] decode_ctrl(input logic [3:0] ctrl);
        logic [4:0] res;
        case (ctrl)
            4'b0001: res = {1'b1, 1'b0, 3'b000};
            4'b0011: res = {1'b1, 1'b0, 3'b001};
            4'b0100: res = {1'b1, 1'b0, 3'b010};
            4'b0101: res = {1'b1, 1'b0, 3'b011};
            4'b0110: res = {1'b1, 1'b0, 3'b100};
            4'b0111: res = {1'b1, 1'b0, 3'b101};
            4'b1001: res = {1'b1, 1'b0, 3'b110};
            4'b1010: res = {1'b1, 1'b0, 3'b111};
            4'b0010: res = {1'b1, 1'b1, 3'b000};
            4'b1000: res = {1'b1, 1'b1, 3'b101};
            default: res = 5'b00000;
        endcase
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];

    logic              req_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [4:0]        dec_s;
    logic [31:0]       word_s;
    logic              instr_valid_s;
    logic [31:0]       instr_s;

    assign dec_s       = decode_ctrl(bus.req_ctrl);
    assign word_s      = {1'b0, dec_s[3], 5'b00000, bus.req_rs2, bus.req_rs1,
                          dec_s[2:0], bus.req_rd, OPC_OP};
    // Ready comes from the registered count only, so a pop never frees a full queue early.
    assign req_ready_s = (count_q < CW'(DEPTH));
    assign accept_s    = bus.req_valid && req_ready_s;
    assign push_s      = accept_s && dec_s[4];

    // Issue FSM: next state, gap countdown and pop request.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != CW'(0)) state_d = ISSUE;
                else                   state_d = IDLE;
            end
            ISSUE: begin
                if (bus.instr_ready && (count_q != CW'(0))) begin
                    pop_s   = 1'b1;
                    gap_d   = GW'(ISSUE_GAP - 2);
                    state_d = GAP;
                end else begin
                    state_d = ISSUE;
                end
            end
            GAP: begin
                if (gap_q == GW'(0)) begin
                    if (count_q != CW'(0)) state_d = ISSUE;
                    else                   state_d = IDLE;
                end else begin
                    gap_d   = gap_q - GW'(1);
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue pointer, occupancy and error-pulse next-state logic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = accept_s && !dec_s[4];
        if (push_s) tail_d = tail_q + PW'(1);
        else        tail_d = tail_q;
        if (pop_s)  head_d = head_q + PW'(1);
        else        head_d = head_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= GW'(0);
            head_q  <= PW'(0);
            tail_q  <= PW'(0);
            count_q <= CW'(0);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Queue storage; cleared on reset so no stale word can ever be presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (push_s) begin
            mem_q[tail_q] <= word_s;
        end else begin
            mem_q[tail_q] <= mem_q[tail_q];
        end
    end

    assign instr_valid_s   = (state_q == ISSUE);
    assign instr_s         = instr_valid_s ? mem_q[head_q] : 32'd0;

    assign bus.req_ready   = req_ready_s;
    assign bus.instr_valid = instr_valid_s;
    assign bus.instr       = instr_s;
    assign bus.func        = instr_s[14:12];
    assign bus.opcode      = instr_s[6:0];
    assign err_illegal     = err_q;
    assign count           = count_q;
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed self-checking bench for alu_instr_encoder (DEPTH=4, ISSUE_GAP=4).
module tb_alu_instr_encoder;
    logic       clk;
    logic       reset;
    logic       err_illegal;
    logic [2:0] count;
    int         checks;
    int         failures;

    alu_instr_encoder_if bus();

    alu_instr_encoder #(.DEPTH(4), .ISSUE_GAP(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .err_illegal (err_illegal),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] c,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        bus.req_valid = v;
        bus.req_ctrl  = c;
        bus.req_rs1   = r1;
        bus.req_rs2   = r2;
        bus.req_rd    = rd;
    endtask

    logic [31:0] exp_q [4];
    logic [31:0] got_w [2];
    int          hs_cyc [2];
    int          n;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.instr_ready = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        step();
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        reset = 1'b0;
        step();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);

        // Basic encode and latency
        set_req(1'b1, 4'b0001, 5'd1, 5'd2, 5'd3);
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("a_count", 32'(count), 32'd1);
        chk("a_valid_early", 32'(bus.instr_valid), 32'd0);
        step();
        chk("a_valid", 32'(bus.instr_valid), 32'd1);
        chk("a_instr", bus.instr, 32'h002081B3);
        chk("a_func", 32'(bus.func), 32'd0);
        chk("a_opcode", 32'(bus.opcode), 32'h33);
        step();
        chk("a_stable", bus.instr, 32'h002081B3);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("a_gap_valid", 32'(bus.instr_valid), 32'd0);
        chk("a_gap_instr", bus.instr, 32'd0);
        chk("a_gap_count", 32'(count), 32'd0);
        repeat (4) step();

        // SUB then SRA, issue spacing with ready held high
        bus.instr_ready = 1'b1;
        set_req(1'b1, 4'b0010, 5'd0, 5'd0, 5'd0);
        step();
        set_req(1'b1, 4'b1000, 5'd0, 5'd0, 5'd0);
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        n = 0;
        hs_cyc[0] = -100; hs_cyc[1] = 100;
        got_w[0] = 32'd0; got_w[1] = 32'd0;
        for (int c = 0; c < 12; c++) begin
            if (bus.instr_valid && n < 2) begin
                got_w[n]  = bus.instr;
                hs_cyc[n] = c;
                n++;
            end
            step();
        end
        bus.instr_ready = 1'b0;
        chk("b_hs_count", 32'(n), 32'd2);
        chk("b_word0", got_w[0], 32'h40000033);
        chk("b_word1", got_w[1], 32'h40005033);
        chk("b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);

        // Illegal code
        set_req(1'b1, 4'b1100, 5'd1, 5'd1, 5'd1);
        chk("c_ready", 32'(bus.req_ready), 32'd1);
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("c_err", 32'(err_illegal), 32'd1);
        chk("c_count", 32'(count), 32'd0);
        step();
        chk("c_err_clr", 32'(err_illegal), 32'd0);
        chk("c_valid", 32'(bus.instr_valid), 32'd0);

        // Fill to full with ready low, then drain
        exp_q[0] = 32'h00001033; exp_q[1] = 32'h00002033;
        exp_q[2] = 32'h00003033; exp_q[3] = 32'h00004033;
        set_req(1'b1, 4'b0011, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b0100, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b0101, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b0110, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b0111, 5'd0, 5'd0, 5'd0);
        chk("d_full_ready", 32'(bus.req_ready), 32'd0);
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("d_count", 32'(count), 32'd4);
        chk("d_head", bus.instr, 32'h00001033);
        step();
        chk("d_stable", bus.instr, 32'h00001033);
        bus.instr_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.instr_valid) begin
                if (n < 4) chk("d_drain", bus.instr, exp_q[n]);
                n++;
            end
            step();
        end
        bus.instr_ready = 1'b0;
        chk("d_drained", 32'(n), 32'd4);
        chk("d_count_end", 32'(count), 32'd0);

        // Reset during GAP
        set_req(1'b1, 4'b1001, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b1010, 5'd0, 5'd0, 5'd0); step();
        set_req(1'b1, 4'b0001, 5'd0, 5'd0, 5'd5); step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("e_count3", 32'(count), 32'd3);
        chk("e_head", bus.instr, 32'h00006033);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("e_gap_valid", 32'(bus.instr_valid), 32'd0);
        chk("e_gap_count", 32'(count), 32'd2);
        reset = 1'b1;
        #1;
        chk("e_rst_count", 32'(count), 32'd0);
        chk("e_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("e_rst_instr", bus.instr, 32'd0);
        step();
        reset = 1'b0;
        step();
        set_req(1'b1, 4'b0001, 5'd1, 5'd2, 5'd3);
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        step();
        chk("e_after_valid", 32'(bus.instr_valid), 32'd1);
        chk("e_after_instr", bus.instr, 32'h002081B3);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        repeat (4) step();

        // Simultaneous push and pop across pointer wrap
        set_req(1'b1, 4'b0001, 5'd0, 5'd0, 5'd1); step();
        set_req(1'b1, 4'b0100, 5'd31, 5'd31, 5'd31); step();
        chk("f_count2", 32'(count), 32'd2);
        chk("f_head", bus.instr, 32'h000000B3);
        set_req(1'b1, 4'b1000, 5'd2, 5'd1, 5'd4);
        bus.instr_ready = 1'b1;
        step();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        chk("f_count_pp", 32'(count), 32'd2);
        exp_q[0] = 32'h01FFAFB3;
        exp_q[1] = 32'h40115233;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.instr_valid) begin
                if (n < 2) chk("f_order", bus.instr, exp_q[n]);
                n++;
            end
            step();
        end
        bus.instr_ready = 1'b0;
        chk("f_drained", 32'(n), 32'd2);
        chk("f_count_end", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
